// File: rtl/score_pkg.sv
// Shared types and default sizing for the score BCD conversion path.
package score_pkg;

    localparam int SCORE_W  = 16;
    localparam int SCORE_ND = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } score_state_t;

    // Index width that stays legal (>=1) for a count of one.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/score_bcd_scheduler_if.sv
// Request/response bundle between score sources, the BCD scheduler and the display.
// rsp_blank exists only when SCORE_BCD_BLANK_EN is defined.
interface score_bcd_scheduler_if
    import score_pkg::*;
#(
    parameter int W    = SCORE_W,
    parameter int ND   = SCORE_ND,
    parameter int NREQ = 2
);
    localparam int IDW = id_width(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_bin;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [4*ND-1:0]   rsp_bcd;
    logic              rsp_ready;
    logic              busy;
`ifdef SCORE_BCD_BLANK_EN
    logic [ND-1:0]     rsp_blank;

    modport master (
        output req_valid, req_bin, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_bcd, busy, rsp_blank
    );
    modport slave (
        input  req_valid, req_bin, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_bcd, busy, rsp_blank
    );
`else
    modport master (
        output req_valid, req_bin, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_bcd, busy
    );
    modport slave (
        input  req_valid, req_bin, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_bcd, busy
    );
`endif

endinterface

// File: rtl/bcd_shift_step.sv
// One double-dabble step: add 3 to every digit >= 5, then shift left taking bit_in.
module bcd_shift_step #(
    parameter int ND = 5
) (
    input  logic [4*ND-1:0] bcd_in,
    input  logic            bit_in,
    output logic [4*ND-1:0] bcd_out
);

    logic [4*ND-1:0] adj;

    always_comb begin
        adj = bcd_in;
        for (int d = 0; d < ND; d++) begin
            if (bcd_in[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = bcd_in[4*d +: 4] + 4'd3;
            end
        end
    end

    assign bcd_out = (adj << 1) | {{(4*ND-1){1'b0}}, bit_in};

endmodule

// File: rtl/score_bcd_scheduler.sv
// Round-robin shared binary-to-BCD converter for the 2048 score sources.
// Optional leading-zero flags via SCORE_BCD_BLANK_EN.
//
// state | meaning
// IDLE  | arbitrate, accept one request
// SHIFT | one add-3/shift step per cycle, W cycles
// DONE  | result held on rsp_* until rsp_ready
module score_bcd_scheduler
    import score_pkg::*;
#(
    parameter int W    = SCORE_W,
    parameter int ND   = SCORE_ND,
    parameter int NREQ = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    score_bcd_scheduler_if.slave   bus
);

    localparam int IDW = id_width(NREQ);
    localparam int CW  = id_width(W);

    score_state_t    state_q, state_d;
    logic [W-1:0]    bin_q;
    logic [4*ND-1:0] bcd_q;
    logic [CW-1:0]   cnt_q;
    logic [IDW-1:0]  last_grant_q;
    logic [4*ND-1:0] rsp_bcd_q;
    logic [IDW-1:0]  rsp_id_q;

    logic            grant_found;
    logic [IDW-1:0]  grant_id;
    logic [NREQ-1:0] grant_oh;
    logic [W-1:0]    grant_bin;
    logic            accept;
    logic [4*ND-1:0] bcd_step;

    bcd_shift_step #(.ND(ND)) u_step (
        .bcd_in  (bcd_q),
        .bit_in  (bin_q[W-1]),
        .bcd_out (bcd_step)
    );

    // Two passes give priority to indices above last_grant, then wrap to 0.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        grant_oh    = '0;
        grant_bin   = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (!grant_found && bus.req_valid[j] && (j > int'(last_grant_q))) begin
                grant_found = 1'b1;
                grant_id    = IDW'(j);
                grant_oh[j] = 1'b1;
                grant_bin   = bus.req_bin[j*W +: W];
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!grant_found && bus.req_valid[j] && (j <= int'(last_grant_q))) begin
                grant_found = 1'b1;
                grant_id    = IDW'(j);
                grant_oh[j] = 1'b1;
                grant_bin   = bus.req_bin[j*W +: W];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        bus.req_ready = '0;
        case (state_q)
            IDLE: begin
                bus.req_ready = grant_oh;
                if (grant_found) begin
                    accept  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q        <= '0;
            bcd_q        <= '0;
            cnt_q        <= '0;
            last_grant_q <= IDW'(NREQ - 1);
            rsp_bcd_q    <= '0;
            rsp_id_q     <= '0;
        end else if (accept) begin
            bin_q        <= grant_bin;
            bcd_q        <= '0;
            cnt_q        <= CW'(W - 1);
            last_grant_q <= grant_id;
        end else if (state_q == SHIFT) begin
            bin_q <= bin_q << 1;
            bcd_q <= bcd_step;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
                rsp_bcd_q <= bcd_step;
                rsp_id_q  <= last_grant_q;
            end
        end
    end

`ifdef SCORE_BCD_BLANK_EN
    logic [ND-1:0] blank_d;
    logic [ND-1:0] blank_q;
    logic          zero_above;

    always_comb begin
        blank_d    = '0;
        zero_above = 1'b1;
        for (int k = ND - 1; k >= 1; k--) begin
            zero_above = zero_above & (bcd_step[4*k +: 4] == 4'd0);
            blank_d[k] = zero_above;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_q <= '0;
        end else if ((state_q == SHIFT) && (cnt_q == '0)) begin
            blank_q <= blank_d;
        end else if ((state_q == DONE) && bus.rsp_ready) begin
            blank_q <= '0;
        end
    end

    assign bus.rsp_blank = blank_q;
`endif

    assign bus.rsp_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.rsp_bcd   = rsp_bcd_q;
    assign bus.rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_score_bcd_scheduler.sv
// Directed bench for score_bcd_scheduler; blanking checks enabled with SCORE_BCD_BLANK_EN.
module tb_score_bcd_scheduler;
    import score_pkg::*;

    localparam int W    = 16;
    localparam int ND   = 5;
    localparam int NREQ = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;
`ifdef SCORE_BCD_BLANK_EN
    logic [ND-1:0] last_blank;
`endif

    score_bcd_scheduler_if #(.W(W), .ND(ND), .NREQ(NREQ)) bus ();

    score_bcd_scheduler #(.W(W), .ND(ND), .NREQ(NREQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs already driven while IDLE; runs one conversion to DONE.
    task automatic serve(input int exp_id, input logic [19:0] exp_bcd, input bit hold);
        int n;
        logic [NREQ-1:0] exp_rdy;
        exp_rdy = NREQ'(1 << exp_id);
        #1;
        chk("grant", 32'(bus.req_ready), 32'(exp_rdy));
        @(posedge clk); #1;
        if (!hold) bus.req_valid = '0;
        chk("busy_shift", 32'(bus.busy), 32'd1);
        n = 0;
        while (!bus.rsp_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 32'(n), 32'(W));
        chk("rsp_bcd", 32'(bus.rsp_bcd), 32'(exp_bcd));
        chk("rsp_id", 32'(bus.rsp_id), 32'(exp_id));
        chk("ready_in_done", 32'(bus.req_ready), 32'd0);
`ifdef SCORE_BCD_BLANK_EN
        last_blank = bus.rsp_blank;
`endif
        if (bus.rsp_ready) begin
            @(posedge clk); #1;
            chk("one_cycle_valid", 32'(bus.rsp_valid), 32'd0);
`ifdef SCORE_BCD_BLANK_EN
            chk("blank_cleared", 32'(bus.rsp_blank), 32'd0);
`endif
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [15:0] vals [5];
        logic [19:0] exps [5];
        int seen;
        vals = '{16'd0, 16'd9, 16'd10, 16'd9999, 16'd2048};
        exps = '{20'h00000, 20'h00009, 20'h00010, 20'h09999, 20'h02048};

        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_bin   = '0;
        bus.rsp_ready = 1'b1;
        #3;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("rst_rsp_bcd", 32'(bus.rsp_bcd), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
`ifdef SCORE_BCD_BLANK_EN
        chk("rst_blank", 32'(bus.rsp_blank), 32'd0);
`endif
        do_reset();

        // Full-scale value
        bus.req_bin[15:0] = 16'd65535;
        bus.req_valid     = 2'b01;
        serve(0, 20'h65535, 1'b0);

        // Single requests alternating between sources
        for (int i = 0; i < 5; i++) begin
            bus.req_bin[(i % 2)*W +: W] = vals[i];
            bus.req_valid = NREQ'(1 << (i % 2));
            serve(i % 2, exps[i], 1'b0);
        end

        // Round robin from reset with both sources held valid
        do_reset();
        bus.req_bin   = {16'd456, 16'd123};
        bus.req_valid = 2'b11;
        serve(0, 20'h00123, 1'b1);
        serve(1, 20'h00456, 1'b1);
        serve(0, 20'h00123, 1'b0);

        // Back-pressure in DONE
        bus.rsp_ready     = 1'b0;
        bus.req_bin[15:0] = 16'd2048;
        bus.req_valid     = 2'b01;
        serve(0, 20'h02048, 1'b0);
        bus.req_bin[31:16] = 16'd7;
        bus.req_valid      = 2'b10;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("hold_bcd", 32'(bus.rsp_bcd), 32'h02048);
            chk("hold_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_valid", 32'(bus.rsp_valid), 32'd0);
        chk("release_busy", 32'(bus.busy), 32'd0);
        chk("release_grant", 32'(bus.req_ready), 32'b10);
        serve(1, 20'h00007, 1'b0);

        // Reset during the 5th SHIFT cycle
        bus.req_bin[15:0] = 16'd9999;
        bus.req_valid     = 2'b01;
        #1;
        @(posedge clk); #1;
        bus.req_valid = '0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_bcd", 32'(bus.rsp_bcd), 32'd0);
        chk("mid_rst_id", 32'(bus.rsp_id), 32'd0);
        chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) seen++;
        end
        chk("no_stale_rsp", 32'(seen), 32'd0);
        bus.req_bin   = {16'd2048, 16'd9999};
        bus.req_valid = 2'b11;
        serve(0, 20'h09999, 1'b0);

`ifdef SCORE_BCD_BLANK_EN
        bus.req_bin[15:0] = 16'd42;
        bus.req_valid     = 2'b01;
        serve(0, 20'h00042, 1'b0);
        chk("blank_42", 32'(last_blank), 32'b11100);
        bus.req_bin[15:0] = 16'd0;
        bus.req_valid     = 2'b01;
        serve(0, 20'h00000, 1'b0);
        chk("blank_0", 32'(last_blank), 32'b11110);
        bus.req_bin[15:0] = 16'd65535;
        bus.req_valid     = 2'b01;
        serve(0, 20'h65535, 1'b0);
        chk("blank_65535", 32'(last_blank), 32'b00000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
